adc_conversion_scheduler: RTL and testbench

- Sequences conversions on two dual-channel serial ADC cores (4 logical channels: core0 ch0/ch1 = ch0/ch1, core1 ch0/ch1 = ch2/ch3).
- Each channel has its own programmable sample period; per core, the block round-robins among due channels.
- Issues read commands and latches results into the 64-bit adcdata bus with per-channel ready pulses.
- Sits between the ADC serial cores and the data-buffer/pipe logic; replaces free-running alternation.

---
 rtl/adc_sched_pkg.sv | 16 +
 rtl/adc_core_sequencer.sv | 173 +++++++++++++++++
 rtl/adc_conversion_scheduler.sv | 45 ++++
 tb/tb_adc_conversion_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC conversion scheduler.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sched_state_e;

    localparam logic [7:0] ADC_CTRL_CH0 = 8'h00;
    localparam logic [7:0] ADC_CTRL_CH1 = 8'h08;
    localparam int         ADC_DATA_W   = 12;
    localparam int         CH_PER_CORE  = 2;

endpackage

// File: rtl/adc_core_sequencer.sv
// One ADC core: two sample timers, round-robin channel pick, read/wait/latch FSM.
// Optional WAIT watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_core_sequencer
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [CH_PER_CORE-1:0]            enable,
    input  logic [CH_PER_CORE*PERIOD_W-1:0]   period,
    input  logic [CH_PER_CORE-1:0]            overrun_clear,
    input  logic [ADC_DATA_W-1:0]             data_in,
    input  logic                              data_ready,
    output logic                              adc_read,
    output logic [7:0]                        adc_control,
    output logic [CH_PER_CORE*16-1:0]         adcdata,
    output logic [CH_PER_CORE-1:0]            adcready,
    output logic [CH_PER_CORE-1:0]            overrun,
    output logic                              timeout
);

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

    sched_state_e                   state_q, state_d;
    logic [PERIOD_W-1:0]            timer_q [CH_PER_CORE];
    logic [PERIOD_W-1:0]            timer_d [CH_PER_CORE];
    logic [CH_PER_CORE-1:0]         pending_q, pending_d;
    logic [CH_PER_CORE-1:0]         overrun_q, overrun_d;
    logic [CH_PER_CORE-1:0]         adcready_q, adcready_d;
    logic [CH_PER_CORE-1:0]         expire, clr;
    logic                           sel_q, sel_d, last_q, last_d, pick;
    logic [7:0]                     ctrl_q, ctrl_d;
    logic [ADC_DATA_W-1:0]          data_q, data_d;
    logic [CH_PER_CORE*16-1:0]      adcdata_q, adcdata_d;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int             WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WDOG_ONE  = WD_W'(1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
`endif

    // A timer expiring in the same cycle as its DONE clear keeps pending set and is not an overrun.
    always_comb begin
        clr[0] = (state_q == ST_DONE) && !sel_q;
        clr[1] = (state_q == ST_DONE) && sel_q;
        for (int k = 0; k < CH_PER_CORE; k++) begin
            expire[k]    = enable[k] && (timer_q[k] <= PERIOD_ONE);
            timer_d[k]   = period[k*PERIOD_W +: PERIOD_W];
            pending_d[k] = 1'b0;
            overrun_d[k] = overrun_q[k];
            if (enable[k]) begin
                if (!expire[k]) begin
                    timer_d[k] = timer_q[k] - PERIOD_ONE;
                end
                pending_d[k] = expire[k] | (pending_q[k] & ~clr[k]);
            end
            if (expire[k] && pending_q[k] && !clr[k]) begin
                overrun_d[k] = 1'b1;
            end else if (overrun_clear[k]) begin
                overrun_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        ctrl_d     = ctrl_q;
        data_d     = data_q;
        adcdata_d  = adcdata_q;
        adcready_d = '0;
        pick       = (pending_q == 2'b11) ? ~last_q : pending_q[1];
`ifdef ADC_SCHED_TIMEOUT_EN
        wdog_d     = '0;
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    state_d = ST_ISSUE;
                    sel_d   = pick;
                    last_d  = pick;
                    ctrl_d  = pick ? ADC_CTRL_CH1 : ADC_CTRL_CH0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (data_ready) begin
                    data_d  = data_in;
                    state_d = ST_DONE;
                end
`ifdef ADC_SCHED_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_ONE;
                end
`endif
            end
            ST_DONE: begin
                // A channel disabled mid-conversion drops its result silently.
                if (enable[sel_q]) begin
                    if (sel_q) begin
                        adcdata_d[31:16] = {4'h0, data_q};
                    end else begin
                        adcdata_d[15:0]  = {4'h0, data_q};
                    end
                    adcready_d[sel_q] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overrun_q  <= '0;
            adcready_q <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            ctrl_q     <= '0;
            data_q     <= '0;
            adcdata_q  <= '0;
            for (int k = 0; k < CH_PER_CORE; k++) begin
                timer_q[k] <= period[k*PERIOD_W +: PERIOD_W];
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            adcready_q <= adcready_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            ctrl_q     <= ctrl_d;
            data_q     <= data_d;
            adcdata_q  <= adcdata_d;
            for (int k = 0; k < CH_PER_CORE; k++) begin
                timer_q[k] <= timer_d[k];
            end
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign adc_read    = (state_q == ST_ISSUE);
    assign adc_control = ctrl_q;
    assign adcdata     = adcdata_q;
    assign adcready    = adcready_q;
    assign overrun     = overrun_q;

endmodule

// File: rtl/adc_conversion_scheduler.sv
// Two independent ADC core sequencers; this level only slices the buses.
// Optional WAIT watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_conversion_scheduler
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W       = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              adc_enable,
    input  logic [4*PERIOD_W-1:0]   sample_period,
    input  logic [3:0]              overrun_clear,
    output logic [1:0]              adc_read,
    output logic [15:0]             adc_control,
    input  logic [23:0]             adc_data_in,
    input  logic [1:0]              adc_data_ready,
    output logic [63:0]             adcdata,
    output logic [3:0]              adcready,
    output logic [3:0]              overrun,
    output logic [1:0]              timeout
);

    for (genvar c = 0; c < 2; c++) begin : g_core
        adc_core_sequencer #(
            .PERIOD_W       (PERIOD_W),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_seq (
            .clk           (clk),
            .rst_n         (rst_n),
            .enable        (adc_enable[c*CH_PER_CORE +: CH_PER_CORE]),
            .period        (sample_period[c*CH_PER_CORE*PERIOD_W +: CH_PER_CORE*PERIOD_W]),
            .overrun_clear (overrun_clear[c*CH_PER_CORE +: CH_PER_CORE]),
            .data_in       (adc_data_in[c*ADC_DATA_W +: ADC_DATA_W]),
            .data_ready    (adc_data_ready[c]),
            .adc_read      (adc_read[c]),
            .adc_control   (adc_control[c*8 +: 8]),
            .adcdata       (adcdata[c*32 +: 32]),
            .adcready      (adcready[c*CH_PER_CORE +: CH_PER_CORE]),
            .overrun       (overrun[c*CH_PER_CORE +: CH_PER_CORE]),
            .timeout       (timeout[c])
        );
    end

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Directed bench for adc_conversion_scheduler with cycle-exact expected values.
// Watchdog steps run only when ADC_SCHED_TIMEOUT_EN is defined.
module tb_adc_conversion_scheduler;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    adc_enable;
    logic [4*PW-1:0] sample_period;
    logic [3:0]    overrun_clear;
    logic [1:0]    adc_read;
    logic [15:0]   adc_control;
    logic [23:0]   adc_data_in;
    logic [1:0]    adc_data_ready;
    logic [63:0]   adcdata;
    logic [3:0]    adcready;
    logic [3:0]    overrun;
    logic [1:0]    timeout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adc_conversion_scheduler #(
        .PERIOD_W       (PW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_enable     (adc_enable),
        .sample_period  (sample_period),
        .overrun_clear  (overrun_clear),
        .adc_read       (adc_read),
        .adc_control    (adc_control),
        .adc_data_in    (adc_data_in),
        .adc_data_ready (adc_data_ready),
        .adcdata        (adcdata),
        .adcready       (adcready),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    // Advance n rising edges and settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                 input logic [PW-1:0] p2, input logic [PW-1:0] p3);
        adc_enable    = en;
        sample_period = {p3, p2, p1, p0};
    endtask

    // Leaves the bench just after the last reset edge with rst_n released.
    task automatic doReset();
        rst_n          = 1'b0;
        adc_data_ready = '0;
        overrun_clear  = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic pulseReady(input int core, input logic [11:0] d);
        if (core == 0) adc_data_in[11:0]  = d;
        else           adc_data_in[23:12] = d;
        adc_data_ready[core] = 1'b1;
        step(1);
        adc_data_ready = '0;
    endtask

    task automatic waitRead(input logic [1:0] mask, input string tag);
        int n;
        n = 0;
        while (((adc_read & mask) == 2'b00) && (n < 50)) begin
            step(1);
            n++;
        end
        checkOutput(tag, 64'(adc_read & mask), 64'(mask));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int reads;
        int ch;
        rst_n          = 1'b0;
        adc_enable     = '0;
        sample_period  = '0;
        overrun_clear  = '0;
        adc_data_in    = '0;
        adc_data_ready = '0;

        // Reset values, then single-channel conversion with period 100
        applyStimulus(4'b0001, 16'd100, 16'd0, 16'd0, 16'd0);
        step(2);
        checkOutput("rst.adc_read",    64'(adc_read),    64'h0);
        checkOutput("rst.adc_control", 64'(adc_control), 64'h0);
        checkOutput("rst.adcdata",     adcdata,          64'h0);
        checkOutput("rst.adcready",    64'(adcready),    64'h0);
        checkOutput("rst.overrun",     64'(overrun),     64'h0);
        checkOutput("rst.timeout",     64'(timeout),     64'h0);
        rst_n = 1'b1;
        step(100);
        checkOutput("A.read_early", 64'(adc_read), 64'h0);
        step(1);
        checkOutput("A.read_first", 64'(adc_read), 64'h1);
        checkOutput("A.ctrl0",      64'(adc_control[7:0]), 64'h00);
        step(19);
        pulseReady(0, 12'hABC);
        checkOutput("A.ready_lat1", 64'(adcready), 64'h0);
        step(1);
        checkOutput("A.ready_pulse", 64'(adcready), 64'h1);
        checkOutput("A.data0", 64'(adcdata[15:0]), 64'h0ABC);
        step(1);
        checkOutput("A.ready_one_cycle", 64'(adcready), 64'h0);
        step(77);
        checkOutput("A.read_before_period", 64'(adc_read), 64'h0);
        step(1);
        checkOutput("A.read_period", 64'(adc_read), 64'h1);
        checkOutput("A.no_overrun",  64'(overrun),  64'h0);
        step(1);
        checkOutput("A.read_one_cycle", 64'(adc_read), 64'h0);

        // Continuous conversion on both core0 channels alternates strictly
        applyStimulus(4'b0011, 16'd0, 16'd0, 16'd0, 16'd0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            ch = i % 2;
            waitRead(2'b01, "B.read");
            checkOutput("B.ctrl", 64'(adc_control[7:0]), (ch == 1) ? 64'h08 : 64'h00);
            step(2);
            pulseReady(0, 12'h100 + 12'(i));
            step(1);
            checkOutput("B.adcready", 64'(adcready), (ch == 1) ? 64'h2 : 64'h1);
            checkOutput("B.adcdata", 64'(adcdata[16*ch +: 16]), 64'h0100 + 64'(i));
        end

        // Reset while ISSUE is active
        waitRead(2'b01, "B.read_pre_reset");
        rst_n = 1'b0;
        step(1);
        checkOutput("R.adc_read", 64'(adc_read),    64'h0);
        checkOutput("R.adcready", 64'(adcready),    64'h0);
        checkOutput("R.adcdata",  adcdata,          64'h0);
        checkOutput("R.overrun",  64'(overrun),     64'h0);
        checkOutput("R.control",  64'(adc_control), 64'h0);
        rst_n = 1'b1;
        step(1);
        checkOutput("R.read_wait", 64'(adc_read), 64'h0);
        step(1);
        checkOutput("R.read_resume", 64'(adc_read), 64'h1);
        checkOutput("R.ctrl_resume", 64'(adc_control[7:0]), 64'h00);

        // Ch2 period 10 with a 30-cycle conversion: overrun and clear priority
        applyStimulus(4'b0100, 16'd0, 16'd0, 16'd10, 16'd0);
        doReset();
        step(10);
        checkOutput("C.read_early", 64'(adc_read), 64'h0);
        step(1);
        checkOutput("C.read", 64'(adc_read), 64'h2);
        checkOutput("C.ctrl", 64'(adc_control[15:8]), 64'h00);
        step(8);
        checkOutput("C.overrun_before", 64'(overrun), 64'h0);
        step(1);
        checkOutput("C.overrun_set", 64'(overrun), 64'h4);
        step(4);
        overrun_clear = 4'b0100;
        step(1);
        overrun_clear = 4'b0000;
        checkOutput("C.overrun_cleared", 64'(overrun), 64'h0);
        step(4);
        overrun_clear = 4'b0100;
        step(1);
        overrun_clear = 4'b0000;
        checkOutput("C.overrun_set_wins", 64'(overrun), 64'h4);
        step(10);
        pulseReady(1, 12'h5A5);
        step(1);
        checkOutput("C.adcready", 64'(adcready), 64'h4);
        checkOutput("C.adcdata",  64'(adcdata[47:32]), 64'h05A5);

        // Ch3 disabled mid-conversion discards its result
        applyStimulus(4'b1000, 16'd0, 16'd0, 16'd0, 16'd10);
        doReset();
        step(11);
        checkOutput("D.read1", 64'(adc_read), 64'h2);
        checkOutput("D.ctrl1", 64'(adc_control[15:8]), 64'h08);
        step(4);
        pulseReady(1, 12'h321);
        step(1);
        checkOutput("D.adcready1", 64'(adcready), 64'h8);
        checkOutput("D.adcdata1",  64'(adcdata[63:48]), 64'h0321);
        step(4);
        checkOutput("D.read2", 64'(adc_read), 64'h2);
        step(1);
        adc_enable = 4'b0000;
        step(2);
        pulseReady(1, 12'h123);
        step(1);
        checkOutput("D.no_adcready", 64'(adcready), 64'h0);
        checkOutput("D.data_kept",   64'(adcdata[63:48]), 64'h0321);
        reads = 0;
        repeat (30) begin
            step(1);
            if (adc_read[1]) reads++;
        end
        checkOutput("D.no_read_disabled", 64'(reads), 64'h0);
        adc_enable = 4'b1000;
        step(10);
        checkOutput("D.read_after_enable_early", 64'(adc_read), 64'h0);
        step(1);
        checkOutput("D.read_after_enable", 64'(adc_read), 64'h2);

`ifdef ADC_SCHED_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=16 and no ready returned
        applyStimulus(4'b0001, 16'd0, 16'd0, 16'd0, 16'd0);
        doReset();
        step(2);
        checkOutput("T.read1", 64'(adc_read), 64'h1);
        step(16);
        checkOutput("T.timeout_before", 64'(timeout), 64'h0);
        step(1);
        checkOutput("T.timeout_set", 64'(timeout), 64'h1);
        step(1);
        checkOutput("T.reissue", 64'(adc_read), 64'h1);
        checkOutput("T.reissue_ctrl", 64'(adc_control[7:0]), 64'h00);
`else
        checkOutput("T.timeout_tied", 64'(timeout), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
